wptr_full_sync: RTL and testbench
=================================

Name: wptr_full_sync

Overview:
- Write-side control for an async FIFO; successor to the plain 2-flop read-pointer synchroniser.
- Synchronises the read domain's Gray read pointer into wclk through a configurable-depth chain.
- Owns the write pointer (binary and Gray) and generates full, almost-full, fill level and a sticky overflow flag.
- Sits between the write-side user logic / dual-port RAM and the read-side pointer logic.

Parameters:
ADDRSIZE, 4, RAM address width; DEPTH = 2**ADDRSIZE; legal range 2..12
SYNC_STAGES, 2, flops in the rptr synchroniser chain; legal range 2..4
AFULL_THRESH, 2, walmost_full asserts when level >= DEPTH - AFULL_THRESH; legal range 1..DEPTH-1

Ports:
wclk  in  1  write clock
wrst_n  in  1  reset; asynchronous, active-low
winc  in  1  write request; accepted only when wfull==0
wovf_clr  in  1  clears sticky wovf
rptr  in  ADDRSIZE+1  Gray read pointer from read domain (asynchronous to wclk)
wptr  out  ADDRSIZE+1  registered Gray write pointer to read domain
waddr  out  ADDRSIZE  RAM write address (low bits of binary wptr)
wfull  out  1  FIFO full, registered
walmost_full  out  1  level >= DEPTH-AFULL_THRESH, registered
wlevel  out  ADDRSIZE+1  occupancy as seen from write side, registered, 0..DEPTH
wq_rptr  out  ADDRSIZE+1  synchronised Gray rptr (last chain stage)
wovf  out  1  sticky: set when winc asserted while wfull==1

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - All sync stages, wbin, wptr, wfull, walmost_full, wlevel and wovf go to 0; waddr = 0.
  - Reset mid-operation drops all state immediately; no partial write is accepted on the reset edge.
- Synchroniser:
  - SYNC_STAGES-deep shift chain clocked by wclk, fed directly from rptr with no combinational logic before stage 1.
  - wq_rptr = last stage.
- Read-pointer decode: rbin = gray2bin(wq_rptr), combinational, ADDRSIZE+1 bits.
- Write pointer:
  - wbin_next = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - wbin and wptr register wbin_next and wgray_next each wclk.
  - waddr = wbin[ADDRSIZE-1:0].
  - wptr changes at most one bit per clock.
- Full flag: wfull <= (wgray_next == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]}).
- Level:
  - wlevel <= wbin_next - rbin, modulo 2**(ADDRSIZE+1).
  - Always 0..DEPTH, and equals DEPTH exactly when wfull.
- Almost-full: walmost_full <= ((wbin_next - rbin) >= DEPTH - AFULL_THRESH).
- Latency:
  - An accepted write is reflected on wptr, waddr, wlevel and wfull at the next wclk edge.
  - An rptr change reaches wq_rptr after SYNC_STAGES edges and wfull/wlevel after SYNC_STAGES+1 edges.
  - Full deassertion is therefore pessimistic (late), never early.
- Write while full: write is rejected, wbin/wptr unchanged, wovf <= 1 at that edge.
- Overflow clear:
  - wovf_clr clears wovf at the next edge.
  - If a rejected write and wovf_clr occur in the same cycle, set wins and wovf = 1.
- Wrap-around: after 2*DEPTH accepted writes, wbin and wptr return to 0; waddr wraps every DEPTH writes.
- Simultaneous write and rptr advance in the same cycle: both are applied in the same cycle, so level is unchanged and wfull is recomputed from the new values.
- No combinational path from any input to any output except waddr (from register) and wq_rptr (register).

Test Plan:
1. Reset with rptr=0, then release → wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0; assert wrst_n=0 mid-run at wptr=5 → all outputs 0 asynchronously.
2. Default params, rptr held 0, 16 back-to-back winc → wfull=1 after 16th edge, wlevel=16, wptr=5'b11000 (gray 16), walmost_full=1 from edge 14 (wlevel=14).
3. While full, winc=1 for 3 cycles → wptr stays 5'b11000, wovf=1. Then wovf_clr=1 alone → wovf=0. Then winc+wovf_clr together while full → wovf=1.
4. From full, change rptr gray 0→1 → wq_rptr=1 after 2 edges, wfull=0 and wlevel=15 after 3 edges; rerun with SYNC_STAGES=3 → 4 edges.
5. Streaming: 40 writes with rptr tracking wptr delayed 4 cycles → wptr returns to 0 after write 32, waddr sequence wraps 15→0, wptr Hamming distance per cycle ≤1, wfull never set, wovf=0.
6. Simultaneous winc and rptr advance at wlevel=14 → wlevel stays 14 and walmost_full stays 1. AFULL_THRESH=4 variant → walmost_full asserts at wlevel=12.

Source files
------------

// File: rtl/wptr_full_sync_if.sv
// Write-side FIFO control bus: write request/overflow clear and the read pointer in,
// write pointer, address and status flags out.
interface wptr_full_sync_if #(
  parameter int unsigned ADDRSIZE = 4
);
  logic                winc;
  logic                wovf_clr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic [ADDRSIZE:0]   wq_rptr;
  logic                wovf;

  modport master (
    output winc, wovf_clr, rptr,
    input  wptr, waddr, wfull, walmost_full, wlevel, wq_rptr, wovf
  );

  modport slave (
    input  winc, wovf_clr, rptr,
    output wptr, waddr, wfull, walmost_full, wlevel, wq_rptr, wovf
  );
endinterface

// File: rtl/wptr_full_sync.sv
// Async FIFO write-side control: rptr synchroniser, binary/Gray write pointer,
// registered full / almost-full / level flags and a sticky overflow flag.
module wptr_full_sync #(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 2
) (
  input logic             wclk,
  input logic             wrst_n,
  wptr_full_sync_if.slave bus
);
  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_THRESH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wq_rptr, rbin, full_ptr;
  logic [PW-1:0] wbin_q, wbin_d, wptr_q, wgray_d, wlevel_q, level_d;
  logic          wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wovf_d, push;

  // Stage 0 samples rptr directly: no logic ahead of the first synchroniser flop.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.rptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    for (int i = 0; i < int'(PW); i++) rbin[i] = ^(wq_rptr >> i);
  end

  always_comb begin
    push     = bus.winc & ~wfull_q;
    wbin_d   = wbin_q + PW'(push);
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    full_ptr = {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]};
    wfull_d  = (wgray_d == full_ptr);
    level_d  = wbin_d - rbin;
    wafull_d = (level_d >= AFULL_LEVEL);
    wovf_d   = wovf_q;
    if (bus.wovf_clr) wovf_d = 1'b0;
    if (bus.winc && wfull_q) wovf_d = 1'b1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= level_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wptr         = wptr_q;
  assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = wafull_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wq_rptr      = wq_rptr;
  assign bus.wovf         = wovf_q;
endmodule

// File: tb/tb_wptr_full_sync.sv
// Bench for wptr_full_sync: two instances (default and SYNC_STAGES=3/AFULL_THRESH=4) share
// stimulus; a behavioural model feeds a scoreboard, plus hand-derived vector table checks.
module tb_wptr_full_sync;
  localparam int AW = 4;

  typedef struct packed {
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic [4:0] wq;
    logic       wovf;
  } obs_t;

  typedef struct packed {
    logic [3:0][4:0] sync;
    logic [4:0]      wbin;
    logic            wfull;
    logic            wafull;
    logic [4:0]      wlevel;
    logic            wovf;
  } mstate_t;

  typedef struct {
    logic       inc;
    logic       clr;
    logic [4:0] rp;
    logic [4:0] wptr;
    logic       full;
    logic       afull;
    logic [4:0] lvl;
    logic [4:0] wq;
    logic       ovf;
    logic       bfull;
    logic       bafull;
  } vec_t;

  logic wclk;
  logic wrst_n;
  int   checks = 0;
  int   errors = 0;

  mstate_t ma, mb;
  obs_t    qa[$];
  obs_t    qb[$];

  wptr_full_sync_if #(.ADDRSIZE(AW)) ifa ();
  wptr_full_sync_if #(.ADDRSIZE(AW)) ifb ();

  wptr_full_sync #(.ADDRSIZE(AW), .SYNC_STAGES(2), .AFULL_THRESH(2)) dut_a (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (ifa)
  );

  wptr_full_sync #(.ADDRSIZE(AW), .SYNC_STAGES(3), .AFULL_THRESH(4)) dut_b (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (ifb)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Behavioural write-side model: full is taken as level == DEPTH.
  function automatic mstate_t mstep(input mstate_t s, input logic inc, input logic clr,
                                    input logic [4:0] rp, input int stages, input int thresh);
    mstate_t    n;
    logic [4:0] rb, nb, d;
    n  = s;
    rb = g2b(s.sync[stages-1]);
    nb = (inc && !s.wfull) ? s.wbin + 5'd1 : s.wbin;
    d  = nb - rb;
    n.wbin   = nb;
    n.wlevel = d;
    n.wfull  = (int'(d) == 16);
    n.wafull = (int'(d) >= 16 - thresh);
    n.wovf   = (inc && s.wfull) ? 1'b1 : (clr ? 1'b0 : s.wovf);
    for (int i = 3; i >= 1; i--) n.sync[i] = s.sync[i-1];
    n.sync[0] = rp;
    return n;
  endfunction

  function automatic obs_t mobs(input mstate_t s, input int stages);
    obs_t o;
    o.wptr   = b2g(s.wbin);
    o.waddr  = s.wbin[3:0];
    o.wfull  = s.wfull;
    o.wafull = s.wafull;
    o.wlevel = s.wlevel;
    o.wq     = s.sync[stages-1];
    o.wovf   = s.wovf;
    return o;
  endfunction

  function automatic obs_t dut_a_obs();
    return {ifa.wptr, ifa.waddr, ifa.wfull, ifa.walmost_full, ifa.wlevel, ifa.wq_rptr, ifa.wovf};
  endfunction

  function automatic obs_t dut_b_obs();
    return {ifb.wptr, ifb.waddr, ifb.wfull, ifb.walmost_full, ifb.wlevel, ifb.wq_rptr, ifb.wovf};
  endfunction

  function automatic vec_t mkv(input logic inc, input logic clr, input logic [4:0] rp,
                               input logic [4:0] wptr, input logic full, input logic afull,
                               input logic [4:0] lvl, input logic [4:0] wq, input logic ovf,
                               input logic bfull, input logic bafull);
    vec_t v;
    v.inc = inc; v.clr = clr; v.rp = rp; v.wptr = wptr; v.full = full; v.afull = afull;
    v.lvl = lvl; v.wq = wq; v.ovf = ovf; v.bfull = bfull; v.bafull = bafull;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic inc, input logic clr, input logic [4:0] rp);
    ifa.winc = inc; ifa.wovf_clr = clr; ifa.rptr = rp;
    ifb.winc = inc; ifb.wovf_clr = clr; ifb.rptr = rp;
  endtask

  // One clock: drive, push model expectations, then pop and compare after the edge.
  task automatic cycle(input logic inc, input logic clr, input logic [4:0] rp);
    obs_t ea, eb;
    drive(inc, clr, rp);
    ma = mstep(ma, inc, clr, rp, 2, 2);
    mb = mstep(mb, inc, clr, rp, 3, 4);
    qa.push_back(mobs(ma, 2));
    qb.push_back(mobs(mb, 3));
    @(posedge wclk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("model_a", 32'(dut_a_obs()), 32'(ea));
    chk("model_b", 32'(dut_b_obs()), 32'(eb));
  endtask

  task automatic reset_chk(input string name);
    chk({name, "_a"}, 32'(dut_a_obs()), 32'd0);
    chk({name, "_b"}, 32'(dut_b_obs()), 32'd0);
  endtask

  vec_t vt [25];

  initial begin
    logic [4:0] prev;
    for (int k = 1; k <= 16; k++)
      vt[k-1] = mkv(1, 0, 0, b2g(5'(k)), k == 16, k >= 14, 5'(k), 0, 0, k == 16, k >= 12);
    vt[16] = mkv(1, 0, 0, 5'b11000, 1, 1, 5'd16, 0, 1, 1, 1);
    vt[17] = mkv(1, 0, 0, 5'b11000, 1, 1, 5'd16, 0, 1, 1, 1);
    vt[18] = mkv(1, 0, 0, 5'b11000, 1, 1, 5'd16, 0, 1, 1, 1);
    vt[19] = mkv(0, 1, 0, 5'b11000, 1, 1, 5'd16, 0, 0, 1, 1);
    vt[20] = mkv(1, 1, 0, 5'b11000, 1, 1, 5'd16, 0, 1, 1, 1);
    vt[21] = mkv(0, 0, 1, 5'b11000, 1, 1, 5'd16, 0, 1, 1, 1);
    vt[22] = mkv(0, 0, 1, 5'b11000, 1, 1, 5'd16, 1, 1, 1, 1);
    vt[23] = mkv(0, 0, 1, 5'b11000, 0, 1, 5'd15, 1, 1, 1, 1);
    vt[24] = mkv(0, 0, 1, 5'b11000, 0, 1, 5'd15, 1, 1, 0, 1);

    // Power-on reset.
    drive(0, 0, 0);
    wrst_n = 1'b0;
    ma = '0;
    mb = '0;
    repeat (2) @(posedge wclk);
    #1;
    reset_chk("por");
    wrst_n = 1'b1;

    // Fill, overflow/clear, then read-pointer arrival through the synchroniser.
    foreach (vt[i]) begin
      cycle(vt[i].inc, vt[i].clr, vt[i].rp);
      chk($sformatf("vec%0d_wptr", i),   32'(ifa.wptr),         32'(vt[i].wptr));
      chk($sformatf("vec%0d_wfull", i),  32'(ifa.wfull),        32'(vt[i].full));
      chk($sformatf("vec%0d_afull", i),  32'(ifa.walmost_full), 32'(vt[i].afull));
      chk($sformatf("vec%0d_wlevel", i), 32'(ifa.wlevel),       32'(vt[i].lvl));
      chk($sformatf("vec%0d_wq", i),     32'(ifa.wq_rptr),      32'(vt[i].wq));
      chk($sformatf("vec%0d_wovf", i),   32'(ifa.wovf),         32'(vt[i].ovf));
      chk($sformatf("vec%0d_bfull", i),  32'(ifb.wfull),        32'(vt[i].bfull));
      chk($sformatf("vec%0d_bafull", i), 32'(ifb.walmost_full), 32'(vt[i].bafull));
    end

    // Bring level to 14 (read bin 2), then write in the cycle the read bin 3 lands.
    repeat (4) cycle(0, 0, b2g(5'd2));
    chk("lvl14_a", 32'(ifa.wlevel), 32'd14);
    cycle(0, 0, b2g(5'd3));
    cycle(0, 0, b2g(5'd3));
    chk("pre_sim_lvl", 32'(ifa.wlevel), 32'd14);
    cycle(1, 0, b2g(5'd3));
    chk("sim_lvl", 32'(ifa.wlevel), 32'd14);
    chk("sim_afull", 32'(ifa.walmost_full), 32'd1);
    chk("sim_wptr", 32'(ifa.wptr), 32'b11001);
    cycle(0, 0, b2g(5'd3));
    chk("sim_lvl_b", 32'(ifb.wlevel), 32'd14);

    // Fresh reset, write to wptr=5, then asynchronous reset mid-cycle with winc held.
    wrst_n = 1'b0;
    #1;
    reset_chk("rst1");
    wrst_n = 1'b1;
    ma = '0;
    mb = '0;
    repeat (5) cycle(1, 0, 0);
    chk("wptr5", 32'(ifa.wptr), 32'b00111);
    #2;
    wrst_n = 1'b0;
    #1;
    reset_chk("async_rst");
    @(posedge wclk);
    #1;
    reset_chk("rst_edge");
    wrst_n = 1'b1;
    ma = '0;
    mb = '0;

    // Streaming: rptr follows wptr four cycles late.
    prev = ifa.wptr;
    for (int j = 0; j < 40; j++) begin
      cycle(1, 0, (j >= 4) ? b2g(5'(j - 4)) : 5'd0);
      chk("stream_waddr", 32'(ifa.waddr), 32'((j + 1) % 16));
      chk("stream_hamming", 32'($countones(prev ^ ifa.wptr) <= 1), 32'd1);
      chk("stream_wfull", 32'(ifa.wfull | ifb.wfull), 32'd0);
      chk("stream_wovf", 32'(ifa.wovf | ifb.wovf), 32'd0);
      if (j == 31) chk("wrap_wptr", 32'(ifa.wptr), 32'd0);
      prev = ifa.wptr;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
